my_fifo: RTL and testbench

//  Single-clock AXI-Stream data FIFO between a PE's result register and the NoC

---
 rtl/my_fifo_if.sv | 42 ++++
 rtl/my_fifo.sv | 62 ++++++
 tb/tb_my_fifo.sv | 128 ++++++++++++
 3 files changed

// File: rtl/my_fifo_if.sv
// my_fifo_if: AXI-Stream write/read sides plus occupancy status of my_fifo (almost flags under MY_FIFO_ALMOST_FLAGS_EN).
interface my_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
);
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [CNT_WIDTH-1:0]  axis_data_count;
  logic [CNT_WIDTH-1:0]  axis_wr_data_count;
  logic [CNT_WIDTH-1:0]  axis_rd_data_count;
`ifdef MY_FIFO_ALMOST_FLAGS_EN
  logic                  almost_full;
  logic                  almost_empty;
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata,
    output axis_data_count, axis_wr_data_count, axis_rd_data_count,
    output almost_full, almost_empty
  );
  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata,
    input  axis_data_count, axis_wr_data_count, axis_rd_data_count,
    input  almost_full, almost_empty
  );
`else
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata,
    output axis_data_count, axis_wr_data_count, axis_rd_data_count
  );
  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata,
    input  axis_data_count, axis_wr_data_count, axis_rd_data_count
  );
`endif
endinterface

// File: rtl/my_fifo.sv
// my_fifo: single-clock first-word-fall-through AXI-Stream FIFO; MY_FIFO_ALMOST_FLAGS_EN adds registered almost_full/almost_empty.
module my_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic      s_axis_aclk,
  input  logic      s_axis_areset,
  my_fifo_if.slave  axis
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, cnt, wr_nxt, rd_nxt, cnt_nxt;
  logic rdy, vld, push, pop, full_nxt;
  assign push     = axis.s_axis_tvalid && rdy;
  assign pop      = vld && axis.m_axis_tready;
  assign wr_nxt   = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nxt   = rd_ptr + {{AW{1'b0}}, pop};
  assign cnt_nxt  = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
  // ready and valid are registered from the post-update state so both change on the push/pop edge
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rdy    <= 1'b0;
      vld    <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      cnt    <= cnt_nxt;
      rdy    <= !full_nxt;
      vld    <= cnt_nxt != '0;
    end
  end
  always_ff @(posedge s_axis_aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= axis.s_axis_tdata;
  end
  assign axis.s_axis_tready      = rdy;
  assign axis.m_axis_tvalid      = vld;
  assign axis.m_axis_tdata       = mem[rd_ptr[AW-1:0]];
  assign axis.axis_data_count    = CNT_WIDTH'(cnt);
  assign axis.axis_wr_data_count = CNT_WIDTH'(cnt);
  assign axis.axis_rd_data_count = CNT_WIDTH'(cnt);
`ifdef MY_FIFO_ALMOST_FLAGS_EN
  logic af, ae;
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      af <= 1'b0;
      ae <= 1'b1;
    end else begin
      af <= 32'(cnt_nxt) >= AF_THRESH;
      ae <= 32'(cnt_nxt) <= AE_THRESH;
    end
  end
  assign axis.almost_full  = af;
  assign axis.almost_empty = ae;
`endif
endmodule

// File: tb/tb_my_fifo.sv
// tb_my_fifo: directed self-checking bench for my_fifo using immediate assertions.
module tb_my_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  my_fifo_if #(.DATA_WIDTH(16), .CNT_WIDTH(32)) axis ();
  my_fifo #(.DATA_WIDTH(16), .DEPTH(16), .CNT_WIDTH(32)) dut (
    .s_axis_aclk  (clk),
    .s_axis_areset(rst),
    .axis         (axis.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_cnt(input string tag, input int exp);
    chk({tag, ".data_count"}, axis.axis_data_count, exp);
    chk({tag, ".wr_count"}, axis.axis_wr_data_count, exp);
    chk({tag, ".rd_count"}, axis.axis_rd_data_count, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic acc;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata  = '0;
    axis.m_axis_tready = 1'b0;
    repeat (3) step();
    chk("rst.tready", axis.s_axis_tready, 0);
    chk("rst.m_tvalid", axis.m_axis_tvalid, 0);
    chk_cnt("rst", 0);
`ifdef MY_FIFO_ALMOST_FLAGS_EN
    chk("rst.af", axis.almost_full, 0);
    chk("rst.ae", axis.almost_empty, 1);
`endif
    rst = 1'b0;
    chk("rel.tready_before_edge", axis.s_axis_tready, 0);
    step();
    chk("rel.tready", axis.s_axis_tready, 1);
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tdata  = 16'h00A5;
    step();
    axis.s_axis_tvalid = 1'b0;
    chk("one.m_tvalid", axis.m_axis_tvalid, 1);
    chk("one.m_tdata", axis.m_axis_tdata, 16'h00A5);
    chk_cnt("one", 1);
    axis.m_axis_tready = 1'b1;
    step();
    axis.m_axis_tready = 1'b0;
    chk("one_pop.m_tvalid", axis.m_axis_tvalid, 0);
    chk_cnt("one_pop", 0);
    for (int i = 0; i < 16; i++) begin
      axis.s_axis_tvalid = 1'b1;
      axis.s_axis_tdata  = 16'(i);
      step();
      chk("fill.count", axis.axis_data_count, i + 1);
`ifdef MY_FIFO_ALMOST_FLAGS_EN
      chk("fill.af", axis.almost_full, 32'(i + 1 >= 14));
      chk("fill.ae", axis.almost_empty, 32'(i + 1 <= 2));
`endif
    end
    chk("full.tready", axis.s_axis_tready, 0);
    chk_cnt("full", 16);
    axis.s_axis_tdata = 16'hBEEF;
    step();
    step();
    chk("full_offer.count", axis.axis_data_count, 16);
    chk("full_offer.head", axis.m_axis_tdata, 16'h0000);
    axis.m_axis_tready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      chk("drain.m_tvalid", axis.m_axis_tvalid, 1);
      chk("drain.m_tdata", axis.m_axis_tdata, k < 16 ? 32'(k) : 32'hBEEF);
      acc = axis.s_axis_tvalid && axis.s_axis_tready;
      step();
      if (acc) axis.s_axis_tvalid = 1'b0;
      if (k == 0) chk("drain.tready_after_pop", axis.s_axis_tready, 1);
    end
    chk("drain.tvalid_dropped", axis.s_axis_tvalid, 0);
    chk("drain.m_tvalid_end", axis.m_axis_tvalid, 0);
    chk_cnt("drain_end", 0);
    axis.s_axis_tvalid = 1'b1;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) chk("stream.m_tdata", axis.m_axis_tdata, 32'h1000 + 32'(j - 1));
      axis.s_axis_tdata = 16'h1000 + 16'(j);
      step();
      chk("stream.count", axis.axis_data_count, 1);
    end
    axis.s_axis_tvalid = 1'b0;
    chk("stream.last", axis.m_axis_tdata, 16'h1027);
    step();
    chk_cnt("stream_end", 0);
    axis.m_axis_tready = 1'b0;
    axis.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      axis.s_axis_tdata = 16'h2000 + 16'(i);
      step();
    end
    axis.s_axis_tvalid = 1'b0;
    chk_cnt("five", 5);
    chk("five.head", axis.m_axis_tdata, 16'h2000);
`ifdef MY_FIFO_ALMOST_FLAGS_EN
    chk("five.ae", axis.almost_empty, 0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt("mid_rst", 0);
    chk("mid_rst.m_tvalid", axis.m_axis_tvalid, 0);
    chk("mid_rst.tready", axis.s_axis_tready, 0);
    step();
    chk("post_rst.tready", axis.s_axis_tready, 1);
    chk("post_rst.m_tvalid", axis.m_axis_tvalid, 0);
    chk_cnt("post_rst", 0);
`ifdef MY_FIFO_ALMOST_FLAGS_EN
    chk("post_rst.ae", axis.almost_empty, 1);
    chk("post_rst.af", axis.almost_full, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
